// File: rtl/gb_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gb_interrupt_ctrl
// Purpose  : Game Boy style interrupt controller. Holds the IF (0xFF0F) and
//            IE (0xFFFF) registers, the interrupt master enable (IME) with
//            the one-instruction EI delay, and a two-state dispatch
//            sequencer that hands the CPU a vector address.
// Ports    : clk, reset             - M clock, async active-high reset
//            data_i/addr/wren       - CPU register write bus
//            data_o                 - combinational register read data
//            irq_*                  - source request pulses (IF bits 0..4)
//            ei_i/di_i/reti_i       - CPU EI / DI / RETI execution pulses
//            instr_done_i           - CPU instruction boundary pulse
//            int_ack_i/int_done_i   - dispatch start / dispatch complete
//            int_req_o              - interrupt request to CPU
//            int_vector_o           - dispatch target (0 when idle)
//            ime_o, wake_o          - master enable state, HALT exit
// Revision : 1.0 - initial release
// ============================================================================
module gb_interrupt_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic [15:0] addr,
    input  logic        wren,
    output logic [7:0]  data_o,
    input  logic        irq_vblank,
    input  logic        irq_stat,
    input  logic        irq_timer,
    input  logic        irq_serial,
    input  logic        irq_joypad,
    input  logic        ei_i,
    input  logic        di_i,
    input  logic        reti_i,
    input  logic        instr_done_i,
    input  logic        int_ack_i,
    input  logic        int_done_i,
    output logic        int_req_o,
    output logic [15:0] int_vector_o,
    output logic        ime_o,
    output logic        wake_o
);

    localparam logic [15:0] c_ADDR_IF = 16'hFF0F;
    localparam logic [15:0] c_ADDR_IE = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_DISPATCH = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_if;
    logic [4:0]  w_if_nxt;
    logic [7:0]  r_ie;
    logic        r_ime;
    logic        w_ime_nxt;
    logic        r_ei_armed;
    logic        w_ei_armed_nxt;
    logic [15:0] r_vector;
    logic [15:0] w_vector_nxt;
    logic [4:0]  w_src;
    logic [4:0]  w_pend;
    logic [4:0]  w_sel_onehot;
    logic [2:0]  w_sel_idx;
    logic [15:0] w_sel_vec;
    logic        w_ack;
    logic        w_wr_if;
    logic        w_wr_ie;

    assign w_src   = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
    assign w_pend  = r_if & r_ie[4:0];
    assign w_wr_if = wren && (addr == c_ADDR_IF);
    assign w_wr_ie = wren && (addr == c_ADDR_IE);

    // Lowest index wins: scan from the top so the last hit is the lowest bit.
    always_comb begin
        w_sel_idx    = 3'd0;
        w_sel_onehot = 5'd0;
        for (int i = 4; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_sel_idx    = 3'(i);
                w_sel_onehot = 5'd0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end

    assign w_sel_vec = VEC_BASE + VEC_STRIDE * {13'd0, w_sel_idx};

    // Dispatch sequencer next state; the vector register is only non-zero
    // while dispatching, so int_vector_o can be driven straight from it.
    always_comb begin
        w_state_nxt  = r_state;
        w_vector_nxt = r_vector;
        w_ack        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (int_ack_i) begin
                    w_ack        = 1'b1;
                    w_state_nxt  = S_DISPATCH;
                    w_vector_nxt = (|w_pend) ? w_sel_vec : 16'h0000;
                end
            end
            S_DISPATCH: begin
                if (int_done_i) begin
                    w_state_nxt  = S_IDLE;
                    w_vector_nxt = 16'h0000;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_vector_nxt = 16'h0000;
            end
        endcase
    end

    // IF update: CPU write, then acknowledge clear, then source pulses on top
    // so a request arriving in the same cycle is never lost.
    always_comb begin
        w_if_nxt = r_if;
        if (w_wr_if) begin
            w_if_nxt = data_i[4:0];
        end
        if (w_ack) begin
            w_if_nxt = w_if_nxt & ~w_sel_onehot;
        end
        w_if_nxt = w_if_nxt | w_src;
    end

    // IME: EI arms and takes effect at the next instruction boundary. The
    // arm check uses the registered flag, so an EI coinciding with a
    // boundary only arms. Later assignments have higher priority; DI last.
    always_comb begin
        w_ime_nxt      = r_ime;
        w_ei_armed_nxt = r_ei_armed;
        if (r_ei_armed && instr_done_i) begin
            w_ime_nxt      = 1'b1;
            w_ei_armed_nxt = 1'b0;
        end
        if (ei_i) begin
            w_ei_armed_nxt = 1'b1;
        end
        if (reti_i) begin
            w_ime_nxt = 1'b1;
        end
        if (w_ack || di_i) begin
            w_ime_nxt      = 1'b0;
            w_ei_armed_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if       <= 5'd0;
            r_ie       <= 8'd0;
            r_ime      <= 1'b0;
            r_ei_armed <= 1'b0;
            r_vector   <= 16'h0000;
        end else begin
            r_if       <= w_if_nxt;
            r_ime      <= w_ime_nxt;
            r_ei_armed <= w_ei_armed_nxt;
            r_vector   <= w_vector_nxt;
            if (w_wr_ie) begin
                r_ie <= data_i;
            end
        end
    end

    always_comb begin
        case (addr)
            c_ADDR_IF: data_o = {3'b111, r_if};
            c_ADDR_IE: data_o = r_ie;
            default:   data_o = 8'hFF;
        endcase
    end

    assign int_req_o    = (r_state == S_IDLE) && r_ime && (|w_pend);
    assign int_vector_o = r_vector;
    assign ime_o        = r_ime;
    assign wake_o       = |w_pend;

endmodule
`default_nettype wire

// File: tb/tb_gb_interrupt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_interrupt_ctrl
// Purpose  : Self-checking bench for gb_interrupt_ctrl: register table,
//            directed multi-cycle sequences and a randomized run against a
//            behavioural model of the interrupt rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_interrupt_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic [15:0] addr = 16'h0000;
    logic        wren = 1'b0;
    logic [7:0]  data_o;
    logic        irq_vblank = 1'b0, irq_stat = 1'b0, irq_timer = 1'b0;
    logic        irq_serial = 1'b0, irq_joypad = 1'b0;
    logic        ei_i = 1'b0, di_i = 1'b0, reti_i = 1'b0, instr_done_i = 1'b0;
    logic        int_ack_i = 1'b0, int_done_i = 1'b0;
    logic        int_req_o;
    logic [15:0] int_vector_o;
    logic        ime_o;
    logic        wake_o;

    always #5 clk = ~clk;

    gb_interrupt_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .data_i       (data_i),
        .addr         (addr),
        .wren         (wren),
        .data_o       (data_o),
        .irq_vblank   (irq_vblank),
        .irq_stat     (irq_stat),
        .irq_timer    (irq_timer),
        .irq_serial   (irq_serial),
        .irq_joypad   (irq_joypad),
        .ei_i         (ei_i),
        .di_i         (di_i),
        .reti_i       (reti_i),
        .instr_done_i (instr_done_i),
        .int_ack_i    (int_ack_i),
        .int_done_i   (int_done_i),
        .int_req_o    (int_req_o),
        .int_vector_o (int_vector_o),
        .ime_o        (ime_o),
        .wake_o       (wake_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [4:0]  m_if;
    logic [7:0]  m_ie;
    bit          m_ime, m_arm, m_disp;
    logic [15:0] m_vec;

    task automatic model_reset();
        m_if = 5'd0; m_ie = 8'd0; m_ime = 0; m_arm = 0; m_disp = 0; m_vec = 16'h0000;
    endtask

    // Applies one clock edge's worth of rules to the model using the inputs
    // currently presented to the DUT.
    task automatic model_edge();
        logic [4:0] src;
        logic [4:0] pend;
        logic [4:0] nif;
        logic [7:0] nie;
        int         sel;
        bit         ack, nime, narm;
        if (reset) begin
            model_reset();
            return;
        end
        src  = {irq_joypad, irq_serial, irq_timer, irq_stat, irq_vblank};
        pend = m_if & m_ie[4:0];
        nif  = m_if;
        nie  = m_ie;
        nime = m_ime;
        narm = m_arm;
        ack  = !m_disp && int_ack_i;
        if (wren && addr == 16'hFF0F) nif = data_i[4:0];
        if (wren && addr == 16'hFFFF) nie = data_i;
        if (ack) begin
            sel = -1;
            for (int i = 0; i < 5; i++) if (sel < 0 && pend[i]) sel = i;
            if (sel >= 0) begin
                nif[sel] = 1'b0;
                m_vec = 16'(32'h40 + 8 * sel);
            end else begin
                m_vec = 16'h0000;
            end
            m_disp = 1;
        end else if (m_disp && int_done_i) begin
            m_disp = 0;
            m_vec  = 16'h0000;
        end
        nif = nif | src;
        if (m_arm && instr_done_i) begin nime = 1; narm = 0; end
        if (ei_i) narm = 1;
        if (reti_i) nime = 1;
        if (ack || di_i) begin nime = 0; narm = 0; end
        m_if = nif; m_ie = nie; m_ime = nime; m_arm = narm;
    endtask

    task automatic check_model();
        logic [4:0] pend;
        pend = m_if & m_ie[4:0];
        check("int_req", {15'd0, int_req_o}, {15'd0, (!m_disp && m_ime && pend != 5'd0)});
        check("vector", int_vector_o, m_vec);
        check("ime", {15'd0, ime_o}, {15'd0, m_ime});
        check("wake", {15'd0, wake_o}, {15'd0, pend != 5'd0});
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_pulses();
        irq_vblank = 0; irq_stat = 0; irq_timer = 0; irq_serial = 0; irq_joypad = 0;
        ei_i = 0; di_i = 0; reti_i = 0; instr_done_i = 0;
        int_ack_i = 0; int_done_i = 0; wren = 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        clear_pulses();
        check_model();
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        wren = 0;
        #1;
        d = data_o;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wren = 1; addr = a; data_i = d;
        cycle();
    endtask

    task automatic apply_reset();
        reset = 1;
        #1;
        model_reset();
        reset = 0;
    endtask

    typedef struct {
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic [15:0] raddr;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [15:0] ra;

        tbl[0] = '{16'hFF0F, 8'h1F, 16'hFF0F, 8'hFF};
        tbl[1] = '{16'hFF0F, 8'h00, 16'hFF0F, 8'hE0};
        tbl[2] = '{16'hFFFF, 8'hA5, 16'hFFFF, 8'hA5};
        tbl[3] = '{16'hFF06, 8'h12, 16'hFF06, 8'hFF};
        tbl[4] = '{16'hFF0F, 8'hEA, 16'hFF0F, 8'hEA};
        tbl[5] = '{16'hFF0E, 8'h1F, 16'hFF0F, 8'hEA};
        tbl[6] = '{16'hFFFE, 8'h3C, 16'hFFFF, 8'hA5};
        tbl[7] = '{16'hFFFF, 8'h00, 16'hFFFF, 8'h00};

        // Reset state
        model_reset();
        #1;
        check("rst_int_req", {15'd0, int_req_o}, 16'd0);
        check("rst_vector", int_vector_o, 16'h0000);
        check("rst_ime", {15'd0, ime_o}, 16'd0);
        check("rst_wake", {15'd0, wake_o}, 16'd0);
        rd(16'hFF0F, d); check("rst_if", {8'd0, d}, 16'h00E0);
        rd(16'hFFFF, d); check("rst_ie", {8'd0, d}, 16'h0000);

        // Source pulse coinciding with reset is dropped
        irq_vblank = 1;
        @(posedge clk);
        #1;
        irq_vblank = 0;
        reset = 0;
        rd(16'hFF0F, d); check("rst_drop_pulse", {8'd0, d}, 16'h00E0);

        // Register table
        for (int i = 0; i < 8; i++) begin
            wr(tbl[i].waddr, tbl[i].wdata);
            rd(tbl[i].raddr, d);
            check($sformatf("table[%0d]", i), {8'd0, d}, {8'd0, tbl[i].exp});
        end

        // Two same-cycle sources, lowest wins, then the second after RETI
        apply_reset();
        wr(16'hFFFF, 8'h05);
        reti_i = 1; cycle();
        check("seq1_ime", {15'd0, ime_o}, 16'd1);
        irq_timer = 1; irq_vblank = 1; cycle();
        rd(16'hFF0F, d); check("seq1_if_both", {8'd0, d}, 16'h00E5);
        check("seq1_req", {15'd0, int_req_o}, 16'd1);
        int_ack_i = 1; cycle();
        check("seq1_vec0", int_vector_o, 16'h0040);
        rd(16'hFF0F, d); check("seq1_if_after_ack", {8'd0, d}, 16'h00E4);
        check("seq1_ime_cleared", {15'd0, ime_o}, 16'd0);
        check("seq1_no_req_dispatch", {15'd0, int_req_o}, 16'd0);
        int_ack_i = 1; cycle();
        check("seq1_ack_ignored", int_vector_o, 16'h0040);
        int_done_i = 1; reti_i = 1; cycle();
        check("seq1_idle_vec", int_vector_o, 16'h0000);
        check("seq1_req2", {15'd0, int_req_o}, 16'd1);
        int_ack_i = 1; cycle();
        check("seq1_vec2", int_vector_o, 16'h0050);
        int_done_i = 1; cycle();

        // EI delay: EI with boundary at N, next boundary at N+3
        apply_reset();
        ei_i = 1; instr_done_i = 1; cycle();
        check("ei_n", {15'd0, ime_o}, 16'd0);
        cycle(); check("ei_n1", {15'd0, ime_o}, 16'd0);
        cycle(); check("ei_n2", {15'd0, ime_o}, 16'd0);
        instr_done_i = 1; cycle();
        check("ei_n3", {15'd0, ime_o}, 16'd1);
        // DI at N+2 cancels the armed EI
        apply_reset();
        ei_i = 1; instr_done_i = 1; cycle();
        cycle();
        di_i = 1; cycle();
        instr_done_i = 1; cycle();
        check("ei_di_cancel", {15'd0, ime_o}, 16'd0);

        // Source pulse beats same-cycle IF write
        apply_reset();
        irq_serial = 1; wr(16'hFF0F, 8'h00);
        rd(16'hFF0F, d); check("src_beats_write", {8'd0, d}, 16'h00E8);
        wr(16'hFF0F, 8'h1F);
        rd(16'hFF0F, d); check("if_write_1f", {8'd0, d}, 16'h00FF);

        // Wake without IME
        apply_reset();
        wr(16'hFFFF, 8'h10);
        irq_joypad = 1; cycle();
        check("wake_no_ime", {15'd0, wake_o}, 16'd1);
        check("req_no_ime", {15'd0, int_req_o}, 16'd0);
        rd(16'hFF06, d); check("unmapped_read", {8'd0, d}, 16'h00FF);

        // IE cleared between request and acknowledge
        apply_reset();
        wr(16'hFFFF, 8'h01);
        reti_i = 1; irq_vblank = 1; cycle();
        check("stale_req", {15'd0, int_req_o}, 16'd1);
        wr(16'hFFFF, 8'h00);
        int_ack_i = 1; cycle();
        check("stale_vec", int_vector_o, 16'h0000);
        rd(16'hFF0F, d); check("stale_if", {8'd0, d}, 16'h00E1);
        check("stale_ime", {15'd0, ime_o}, 16'd0);
        int_done_i = 1; cycle();

        // Asynchronous reset in the middle of a dispatch
        apply_reset();
        wr(16'hFFFF, 8'h01);
        reti_i = 1; irq_vblank = 1; cycle();
        int_ack_i = 1; cycle();
        check("mid_disp_vec", int_vector_o, 16'h0040);
        #1;
        reset = 1;
        #1;
        check("async_rst_vec", int_vector_o, 16'h0000);
        check("async_rst_req", {15'd0, int_req_o}, 16'd0);
        check("async_rst_ime", {15'd0, ime_o}, 16'd0);
        rd(16'hFF0F, d); check("async_rst_if", {8'd0, d}, 16'h00E0);
        rd(16'hFFFF, d); check("async_rst_ie", {8'd0, d}, 16'h0000);
        model_reset();
        reset = 0;
        wr(16'hFFFF, 8'h01);
        reti_i = 1; irq_vblank = 1; cycle();
        check("async_rst_idle", {15'd0, int_req_o}, 16'd1);

        // Randomized run against the model
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            irq_vblank   = ($urandom_range(7) == 0);
            irq_stat     = ($urandom_range(7) == 0);
            irq_timer    = ($urandom_range(7) == 0);
            irq_serial   = ($urandom_range(7) == 0);
            irq_joypad   = ($urandom_range(7) == 0);
            ei_i         = ($urandom_range(11) == 0);
            di_i         = ($urandom_range(15) == 0);
            reti_i       = ($urandom_range(11) == 0);
            instr_done_i = ($urandom_range(2) == 0);
            int_ack_i    = ($urandom_range(4) == 0);
            int_done_i   = ($urandom_range(3) == 0);
            wren         = ($urandom_range(3) == 0);
            case ($urandom_range(2))
                0:       ra = 16'hFF0F;
                1:       ra = 16'hFFFF;
                default: ra = 16'hFF06;
            endcase
            addr   = ra;
            data_i = 8'($urandom);
            cycle();
            rd(16'hFF0F, d); check("rand_if", {8'd0, d}, {8'd0, 3'b111, m_if});
            rd(16'hFFFF, d); check("rand_ie", {8'd0, d}, {8'd0, m_ie});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
